// File: rtl/game_pkg.sv
// Shared constants and types for the player-input front end of the dungeon game.
package game_pkg;

    localparam int NUM_DIRS = 4;
    localparam int DIR_N    = 0;
    localparam int DIR_S    = 1;
    localparam int DIR_E    = 2;
    localparam int DIR_W    = 3;

    localparam logic [7:0] MOVE_CNT_MAX = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == MOVE_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/move_encoder_if.sv
// Button inputs, enable and move outputs between the board/game top and move_encoder.
interface move_encoder_if;

    logic       btn_n;
    logic       btn_s;
    logic       btn_e;
    logic       btn_w;
    logic       enable;
    logic       n;
    logic       s;
    logic       e;
    logic       w;
    logic       conflict;
    logic [7:0] move_cnt;

    modport master (
        output btn_n, btn_s, btn_e, btn_w, enable,
        input  n, s, e, w, conflict, move_cnt
    );

    modport slave (
        input  btn_n, btn_s, btn_e, btn_w, enable,
        output n, s, e, w, conflict, move_cnt
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw pushbutton.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any agreeing sample restarts the count of consecutive disagreements.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/move_encoder.sv
// Debounced pushbuttons to single-cycle n/s/e/w move pulses, with conflict
// rejection, auto-repeat lockout until full release, and a saturating move count.
module move_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic            clk,
    input  logic            reset,
    move_encoder_if.slave   bus
);

    logic [NUM_DIRS-1:0] w_btn_raw;
    logic [NUM_DIRS-1:0] w_stable;
    logic [NUM_DIRS-1:0] r_stable_d;
    logic [NUM_DIRS-1:0] r_rise;
    logic [NUM_DIRS-1:0] r_move;
    logic [NUM_DIRS-1:0] w_move_next;
    logic                r_conflict;
    logic                w_conflict_next;
    logic [7:0]          r_move_cnt;
    logic [7:0]          w_cnt_next;
    logic                w_any_rise;
    logic                w_single_rise;
    state_t              r_state;
    state_t              w_state_next;

    assign w_btn_raw[DIR_N] = bus.btn_n;
    assign w_btn_raw[DIR_S] = bus.btn_s;
    assign w_btn_raw[DIR_E] = bus.btn_e;
    assign w_btn_raw[DIR_W] = bus.btn_w;

    generate
        for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk      (clk),
                .reset    (reset),
                .i_btn    (w_btn_raw[gi]),
                .o_stable (w_stable[gi])
            );
        end
    endgenerate

    // Rise is registered so a move appears DEBOUNCE_CYCLES+3 edges after the first sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
            r_rise     <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_rise     <= w_stable & ~r_stable_d;
        end
    end

    assign w_any_rise    = (r_rise != '0);
    assign w_single_rise = $onehot(r_rise);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_move     <= '0;
            r_conflict <= 1'b0;
            r_move_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_move     <= w_move_next;
            r_conflict <= w_conflict_next;
            r_move_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_rise) w_state_next = ST_HOLD;
            ST_HOLD: if (w_stable == '0) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A disabled press still locks out until release, so it never fires late.
    always_comb begin
        w_move_next     = '0;
        w_conflict_next = 1'b0;
        w_cnt_next      = r_move_cnt;
        if (r_state == ST_IDLE && w_any_rise && bus.enable) begin
            if (w_single_rise) begin
                w_move_next = r_rise;
                w_cnt_next  = sat_inc(r_move_cnt);
            end else begin
                w_conflict_next = 1'b1;
            end
        end
    end

    assign bus.n        = r_move[DIR_N];
    assign bus.s        = r_move[DIR_S];
    assign bus.e        = r_move[DIR_E];
    assign bus.w        = r_move[DIR_W];
    assign bus.conflict = r_conflict;
    assign bus.move_cnt = r_move_cnt;

endmodule

// File: doc/move_encoder.md
Name: move_encoder

Overview:
- Player-input front end for the dungeon game. Converts four raw, asynchronous, bouncing pushbuttons into clean single-cycle n/s/e/w move pulses for the room FSM.
- Per button: synchronise and debounce. Then detect new presses, reject ambiguous multi-button presses, and lock out auto-repeat until all buttons are released.
- Sits between board pushbuttons and the game top; also counts accepted moves for the score display.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive samples a synchronised level must differ from the stable level before the stable level flips (4 in simulation; board build overrides).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_n  in  1  raw north pushbutton, asynchronous, may bounce.
- btn_s  in  1  raw south pushbutton.
- btn_e  in  1  raw east pushbutton.
- btn_w  in  1  raw west pushbutton.
- enable  in  1  moves permitted; the top drives it with ~(win | d).
- n  out  1  one-cycle north move pulse.
- s  out  1  one-cycle south move pulse.
- e  out  1  one-cycle east move pulse.
- w  out  1  one-cycle west move pulse.
- conflict  out  1  one-cycle pulse when a press is rejected as ambiguous.
- move_cnt  out  8  accepted moves, saturating at 255.

Behaviour:
- Reset (synchronous, active-high; clk/reset fixed as above):
  - All outputs 0, move_cnt 0.
  - Sync flops, stable levels and debounce counters 0; FSM to IDLE.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - If sync == stable, counter clears to 0.
  - If sync != stable, counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and counter <= 0.
  - Any agreeing sample restarts the count.
- Edge detect: rise[i] = stable[i] & ~stable_d[i]; a falling edge never generates a move.
- Latency: button high first sampled at edge k (held) -> move pulse visible after edge k+DEBOUNCE_CYCLES+3 (7 edges at default).
- FSM states:
  - IDLE:
    - No rise -> stay IDLE.
    - Exactly one rise and enable=1 -> assert the matching output for one cycle, move_cnt+1 (hold at 255), go HOLD.
    - Two or more rises in the same cycle -> conflict pulse, no move, go HOLD.
    - Any rise with enable=0 -> no pulse, no conflict, go HOLD.
  - HOLD: no moves or conflicts, whatever else is pressed; go IDLE in the cycle after all four stable levels read 0.
- All outputs are registered. Each pulse is exactly one cycle; at most one of n/s/e/w/conflict is high in any cycle.
- enable is sampled only in IDLE. Dropping it while in HOLD has no effect.
- Reset mid-operation clears everything. A button held through reset release counts as a fresh press and pulses DEBOUNCE_CYCLES+3 cycles after the first post-reset sample.
- A second button pressed while the first is still held is ignored, because the FSM is in HOLD.

Decomposition:
- Shared package game_pkg:
  - direction indices DIR_N=0, DIR_S=1, DIR_E=2, DIR_W=3;
  - FSM state encoding ST_IDLE / ST_HOLD;
  - MOVE_CNT_MAX=255.
- Sub-module btn_debounce: 2-flop synchroniser plus counter debounce, DEBOUNCE_CYCLES parameter, outputs the stable level; instantiated four times.
- Edge detect, FSM and counter live in move_encoder.

Test Plan:
- Clean press: btn_n held high from edge 10 -> n high for exactly one cycle after edge 17; move_cnt=1; s/e/w/conflict stay 0.
- Bounce rejection: btn_e high for 3 cycles, low 1, high 2, low -> no pulse, move_cnt unchanged; then a steady 10-cycle press -> single e pulse.
- Simultaneous press: btn_n and btn_w rise on the same edge, held 20 cycles -> one conflict pulse, no n/w; after release, a btn_s press -> s pulse.
- No auto-repeat: btn_w held 100 cycles with btn_s pressed at cycle 50 -> exactly one w pulse, no s; release all, press s -> one s pulse.
- Enable gating: enable=0, press btn_n -> no pulse; raise enable while n is still held -> still no pulse; release, press again -> n pulse.
- Reset and saturation: reset mid-hold -> outputs 0, then one n pulse 7 cycles after release; 260 clean presses -> move_cnt stops at 255.
